// File: rtl/pwm_fade_seq_pkg.sv
// pwm_fade_pkg: shared types, widths and the gamma curve for the PWM fade sequencer.
package pwm_fade_pkg;
  localparam int DUTY_W = 8;
  localparam int PERIOD_LEN = 256;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;
  function automatic logic [DUTY_W-1:0] gamma(input logic [DUTY_W-1:0] x);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, x} * {{DUTY_W{1'b0}}, x};
    return (x == '1) ? '1 : sq[2*DUTY_W-1:DUTY_W];
  endfunction
endpackage

// File: rtl/pwm_fade_seq_if.sv
// pwm_fade_seq_if: control and duty signals between a controller (master) and the fade sequencer (slave).
interface pwm_fade_seq_if;
  import pwm_fade_pkg::*;
  logic              EN;
  logic              START;
  logic              STOP;
  logic              LOOP;
  logic [DUTY_W-1:0] STEP;
  logic [DUTY_W-1:0] DUTY;
  logic              BUSY;
  logic              PERIOD_TICK;
  modport master (output EN, START, STOP, LOOP, STEP, input DUTY, BUSY, PERIOD_TICK);
  modport slave  (input EN, START, STOP, LOOP, STEP, output DUTY, BUSY, PERIOD_TICK);
endinterface

// File: rtl/pwm_fade_seq_tick_gen.sv
// fade_tick_gen: PWM period counter and step divider; clr realigns both when a sequence starts.
module fade_tick_gen
  import pwm_fade_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic step_ev
);
  logic [7:0] cnt;
  logic [7:0] div;
  assign tick = en && !RST && cnt == 8'(PERIOD_LEN - 1);
  assign step_ev = tick && div == 8'(DIV - 1);
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
      div <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (tick) div <= step_ev ? '0 : div + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_fade_seq.sv
// pwm_fade_seq: breathing duty sequencer for the 8-bit PWM stage; define FADE_GAMMA_EN for a squared
// brightness curve on DUTY (one extra clock of latency).
module pwm_fade_seq
  import pwm_fade_pkg::*;
#(
  parameter int DIV        = 1,
  parameter int HOLD_TICKS = 4,
  parameter int MAX_DUTY   = 255
) (
  input logic           CLK,
  input logic           RST,
  pwm_fade_seq_if.slave bus
);
  state_t            state;
  logic [DUTY_W-1:0] duty_lin;
  logic [7:0]        hold_cnt;
  logic              stop_flag;
  logic              tick;
  logic              step_ev;
  logic              go;
  logic              hold_done;
  logic [DUTY_W-1:0] step_eff;
  logic [DUTY_W:0]   up_sum;
  assign go = bus.EN && state == IDLE && bus.START && !bus.STOP;
  fade_tick_gen #(.DIV(DIV)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .en     (bus.EN),
    .clr    (go),
    .tick   (tick),
    .step_ev(step_ev)
  );
  assign step_eff = bus.STEP == '0 ? 8'd1 : bus.STEP;
  assign up_sum = {1'b0, duty_lin} + {1'b0, step_eff};
  assign hold_done = tick && hold_cnt == 8'(HOLD_TICKS - 1);
  assign bus.BUSY = state != IDLE;
  assign bus.PERIOD_TICK = tick;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      duty_lin  <= '0;
      hold_cnt  <= '0;
      stop_flag <= 1'b0;
    end else if (bus.EN) begin
      if (state == IDLE) begin
        if (go) begin
          state     <= RAMP_UP;
          stop_flag <= 1'b0;
          hold_cnt  <= '0;
        end
      end else if (bus.STOP && state != RAMP_DN) begin
        state     <= RAMP_DN;
        hold_cnt  <= '0;
        stop_flag <= 1'b1;
      end else begin
        if (bus.STOP) stop_flag <= 1'b1;
        case (state)
          RAMP_UP: if (step_ev) begin
            if (up_sum >= 9'(MAX_DUTY)) begin
              duty_lin <= 8'(MAX_DUTY);
              state    <= HOLD_HI;
              hold_cnt <= '0;
            end else duty_lin <= up_sum[DUTY_W-1:0];
          end
          RAMP_DN: if (step_ev) begin
            if (duty_lin <= step_eff) begin
              duty_lin <= '0;
              hold_cnt <= '0;
              state    <= (bus.LOOP && !stop_flag && !bus.STOP) ? HOLD_LO : IDLE;
            end else duty_lin <= duty_lin - step_eff;
          end
          HOLD_HI, HOLD_LO: if (tick) begin
            hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
            if (hold_done) state <= state == HOLD_HI ? RAMP_DN : (bus.LOOP ? RAMP_UP : IDLE);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef FADE_GAMMA_EN
  logic [DUTY_W-1:0] duty_q;
  always_ff @(posedge CLK) begin
    if (RST) duty_q <= '0;
    else if (bus.EN) duty_q <= gamma(duty_lin);
  end
  assign bus.DUTY = duty_q;
`else
  assign bus.DUTY = duty_lin;
`endif
endmodule

// File: tb/tb_pwm_fade_seq.sv
// tb_pwm_fade_seq: directed breathing-profile scenarios checked against a per-period behavioural model.
module tb_pwm_fade_seq;
  localparam int DIV  = 1;
  localparam int HOLD = 4;
  localparam int MAXD = 255;
`ifdef FADE_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  pwm_fade_seq_if bus();
  pwm_fade_seq #(.DIV(DIV), .HOLD_TICKS(HOLD), .MAX_DUTY(MAXD)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always #5 CLK = ~CLK;
  int checks = 0;
  int errors = 0;
  function automatic int gam(int x);
    return x == 255 ? 255 : (x * x) / 256;
  endfunction
  function automatic int outv(int lin);
    return LAT ? gam(lin) : lin;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle, 1 up, 2 hold high, 3 down, 4 hold low; m_pos is position within the PWM period
  int m_pos, m_div, m_hold, m_lin, m_ph, m_g, s;
  bit m_stop, armed, tk, ev;
  always @(posedge CLK) begin
    if (RST) begin
      m_pos = 0; m_div = 0; m_hold = 0; m_lin = 0; m_ph = 0; m_g = 0; m_stop = 0; armed = 1;
    end else if (bus.EN) begin
      tk = m_pos == 255;
      ev = tk && m_div == DIV - 1;
      m_pos = (m_pos + 1) % 256;
      if (tk) m_div = (m_div + 1) % DIV;
      s = bus.STEP == 0 ? 1 : int'(bus.STEP);
      m_g = gam(m_lin);
      if (m_ph == 0) begin
        if (bus.START && !bus.STOP) begin
          m_ph = 1; m_pos = 0; m_div = 0; m_stop = 0; m_hold = 0;
        end
      end else if (bus.STOP && m_ph != 3) begin
        m_ph = 3; m_hold = 0; m_stop = 1;
      end else begin
        if (bus.STOP) m_stop = 1;
        if (m_ph == 1 && ev) begin
          m_lin = (m_lin + s < MAXD) ? m_lin + s : MAXD;
          if (m_lin == MAXD) begin m_ph = 2; m_hold = 0; end
        end else if (m_ph == 3 && ev) begin
          m_lin = m_lin > s ? m_lin - s : 0;
          if (m_lin == 0) begin m_ph = (bus.LOOP && !m_stop) ? 4 : 0; m_hold = 0; end
        end else if ((m_ph == 2 || m_ph == 4) && tk) begin
          m_hold++;
          if (m_hold == HOLD) begin
            m_hold = 0;
            m_ph = m_ph == 2 ? 3 : (bus.LOOP ? 1 : 0);
          end
        end
      end
    end
  end
  always @(negedge CLK) begin
    if (armed) begin
      chk("model duty", int'(bus.DUTY), LAT ? m_g : m_lin);
      chk("model busy", int'(bus.BUSY), int'(m_ph != 0));
      chk("model tick", int'(bus.PERIOD_TICK), int'(bus.EN && !RST && m_pos == 255));
    end
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask
  task automatic to_tick(output int n);
    n = 0;
    while (!bus.PERIOD_TICK && n < 2000) begin cyc(1); n++; end
    chk("tick within bound", int'(n < 2000), 1);
    cyc(1 + LAT);
  endtask
  task automatic exp_d(string nm, int lin, int busy);
    chk({nm, " duty"}, int'(bus.DUTY), outv(lin));
    chk({nm, " busy"}, int'(bus.BUSY), busy);
  endtask
  task automatic pulse(bit st, bit sp);
    bus.START = st; bus.STOP = sp;
    cyc(1);
    bus.START = 0; bus.STOP = 0;
  endtask
  int n;
  int up_seq[4] = '{64, 128, 192, 255};
  int dn_seq[4] = '{191, 127, 63, 0};
  initial begin
    #20_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.EN = 1; bus.START = 0; bus.STOP = 0; bus.LOOP = 0; bus.STEP = 0;
    RST = 1;
    cyc(1);
    pulse(1, 0);
    cyc(1);
    RST = 0;
    exp_d("reset", 0, 0);
    chk("reset tick", int'(bus.PERIOD_TICK), 0);
    // one-shot ramp
    bus.STEP = 64; bus.LOOP = 0;
    pulse(1, 0);
    exp_d("start", 0, 1);
    to_tick(n);
    chk("first step latency", n, 255);
    exp_d("up0", 64, 1);
    for (int i = 1; i < 4; i++) begin to_tick(n); exp_d("up", up_seq[i], 1); end
    for (int i = 0; i < 4; i++) begin to_tick(n); exp_d("hold", 255, 1); end
    for (int i = 0; i < 4; i++) begin to_tick(n); exp_d("down", dn_seq[i], int'(i < 3)); end
    to_tick(n);
    exp_d("oneshot idle", 0, 0);
    // saturation
    bus.STEP = 200;
    pulse(1, 0);
    to_tick(n); exp_d("sat200", 200, 1);
    to_tick(n); exp_d("sat255", 255, 1);
    to_tick(n); exp_d("sat hold", 255, 1);
    bus.STEP = 128;
    pulse(0, 1);
    to_tick(n); exp_d("sat down", 127, 1);
    to_tick(n); exp_d("sat end", 0, 0);
    // step 0 behaves as 1
    bus.STEP = 0;
    pulse(1, 0);
    for (int i = 1; i <= 3; i++) begin to_tick(n); exp_d("step0 up", i, 1); end
    pulse(0, 1);
    for (int i = 2; i >= 0; i--) begin to_tick(n); exp_d("step0 down", i, int'(i > 0)); end
    // stop in HOLD_HI with LOOP=1
    bus.STEP = 64; bus.LOOP = 1;
    pulse(1, 0);
    for (int i = 0; i < 4; i++) begin to_tick(n); exp_d("loop up", up_seq[i], 1); end
    to_tick(n); to_tick(n);
    cyc(50);
    pulse(0, 1);
    exp_d("stop hold", 255, 1);
    for (int i = 0; i < 4; i++) begin to_tick(n); exp_d("stop down", dn_seq[i], int'(i < 3)); end
    to_tick(n);
    exp_d("no restart", 0, 0);
    bus.LOOP = 0;
    // EN gating
    pulse(1, 0);
    to_tick(n); exp_d("en up", 64, 1);
    cyc(100 - LAT);
    bus.EN = 0;
    cyc(1000);
    exp_d("en frozen", 64, 1);
    chk("en frozen tick", int'(bus.PERIOD_TICK), 0);
    bus.EN = 1;
    to_tick(n);
    chk("en resume latency", n, 155);
    exp_d("en resumed", 128, 1);
    pulse(0, 1);
    to_tick(n); exp_d("en down", 64, 1);
    to_tick(n); exp_d("en end", 0, 0);
    // START and STOP together in IDLE
    pulse(1, 1);
    cyc(2);
    exp_d("start+stop", 0, 0);
`ifdef FADE_GAMMA_EN
    bus.STEP = 128;
    pulse(1, 0);
    n = 0;
    while (!bus.PERIOD_TICK && n < 2000) begin cyc(1); n++; end
    cyc(1);
    chk("gamma lag", int'(bus.DUTY), 0);
    cyc(1);
    chk("gamma 128", int'(bus.DUTY), 64);
    pulse(0, 1);
    to_tick(n); exp_d("gamma end", 0, 0);
`endif
    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
